// File: rtl/iob_dbus_wbuf.sv
// Posted-write buffer between the core data bus and the interconnect: writes are acked from a
// DEPTH-entry FIFO and drained in order; reads issue only once every buffered write has completed.
module iob_dbus_wbuf #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   input  logic [ADDR_W-1:0]     s_addr,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [DATA_W/8-1:0]   s_wstrb,
   output logic [DATA_W-1:0]     s_rdata,
   output logic                  s_ready,
   output logic                  m_valid,
   output logic [ADDR_W-1:0]     m_addr,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_wstrb,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic                  m_ready,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  empty,
   output logic                  full
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

   logic [ADDR_W-1:0]     addr_mem [DEPTH];
   logic [DATA_W-1:0]     data_mem [DEPTH];
   logic [STRB_W-1:0]     strb_mem [DEPTH];

   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   level_q;
   state_t                state_q, state_d;
   logic                  m_valid_q, m_valid_d;
   logic [ADDR_W-1:0]     m_addr_q, m_addr_d;
   logic [DATA_W-1:0]     m_wdata_q, m_wdata_d;
   logic [STRB_W-1:0]     m_wstrb_q, m_wstrb_d;
   logic                  s_ready_q, s_ready_d;
   logic [DATA_W-1:0]     s_rdata_q, s_rdata_d;
   logic                  s_is_wr, push, pop;

   assign level   = level_q;
   assign empty   = (level_q == '0);
   assign full    = (level_q == (DEPTH_LOG2+1)'(DEPTH));
   assign s_ready = s_ready_q;
   assign s_rdata = s_rdata_q;
   assign m_valid = m_valid_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_wstrb = m_wstrb_q;

   // The ack cycle still shows the master's old request, so it must never be taken again.
   assign s_is_wr = |s_wstrb;
   assign push    = s_valid && s_is_wr && !full && !s_ready_q;

   always_comb begin
      state_d   = state_q;
      m_valid_d = m_valid_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_wstrb_d = m_wstrb_q;
      s_rdata_d = s_rdata_q;
      s_ready_d = push;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (level_q != '0) begin
               m_addr_d  = addr_mem[rd_ptr_q];
               m_wdata_d = data_mem[rd_ptr_q];
               m_wstrb_d = strb_mem[rd_ptr_q];
               m_valid_d = 1'b1;
               state_d   = ST_WR;
            end else if (s_valid && !s_is_wr && !s_ready_q) begin
               m_addr_d  = s_addr;
               m_wdata_d = '0;
               m_wstrb_d = '0;
               m_valid_d = 1'b1;
               state_d   = ST_RD;
            end
         end
         ST_WR: begin
            if (m_ready) begin
               pop       = 1'b1;
               m_valid_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         ST_RD: begin
            if (m_ready) begin
               s_rdata_d = m_rdata;
               s_ready_d = 1'b1;
               m_valid_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         m_valid_q <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_wstrb_q <= '0;
         s_ready_q <= 1'b0;
         s_rdata_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
      end else begin
         state_q   <= state_d;
         m_valid_q <= m_valid_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_wstrb_q <= m_wstrb_d;
         s_ready_q <= s_ready_d;
         s_rdata_q <= s_rdata_d;
         if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + (DEPTH_LOG2+1)'(1);
            2'b01:   level_q <= level_q - (DEPTH_LOG2+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked entirely by the pointers and level.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= s_addr;
         data_mem[wr_ptr_q] <= s_wdata;
         strb_mem[wr_ptr_q] <= s_wstrb;
      end
   end

endmodule

// File: tb/tb_iob_dbus_wbuf.sv
// Bench for iob_dbus_wbuf: a latency-programmable memory responder records downstream requests,
// tasks compare them against a queue of requests expected from the driven stimulus.
`timescale 1ns/1ps
module tb_iob_dbus_wbuf;
   logic        clk, rst;
   logic        s_valid, s_ready, m_valid, m_ready, empty, full;
   logic [31:0] s_addr, s_wdata, s_rdata, m_addr, m_wdata, m_rdata;
   logic [3:0]  s_wstrb, m_wstrb;
   logic [2:0]  level;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int          c;
   } req_t;

   req_t        exp_q[$];
   req_t        obs_q[$];
   logic [31:0] mem [logic [31:0]];
   int          cyc = 0;
   int          mem_lat = 1;
   int          resp_cnt = 0;
   bit          resp_seen = 0;
   req_t        resp_cur;
   int          n_checks = 0;
   int          n_errors = 0;

   iob_dbus_wbuf #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(2)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_rdata(s_rdata), .s_ready(s_ready),
      .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_rdata(m_rdata), .m_ready(m_ready),
      .level(level), .empty(empty), .full(full)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: m_ready arrives mem_lat cycles after m_valid is first seen.
   initial begin
      m_ready = 0;
      m_rdata = 0;
      forever begin
         @(posedge clk); #1;
         m_ready = 0;
         if (rst) begin
            resp_cnt  = 0;
            resp_seen = 0;
         end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               m_ready   = 1;
               resp_seen = 0;
               if (resp_cur.s == 0) begin
                  m_rdata = mem.exists(resp_cur.a) ? mem[resp_cur.a] : 32'h0;
               end else begin
                  logic [31:0] w;
                  w = mem.exists(resp_cur.a) ? mem[resp_cur.a] : 32'h0;
                  for (int b = 0; b < 4; b++)
                     if (resp_cur.s[b]) w[8*b +: 8] = resp_cur.d[8*b +: 8];
                  mem[resp_cur.a] = w;
               end
            end
         end else if (m_valid && !resp_seen) begin
            resp_seen = 1;
            resp_cur  = '{m_addr, m_wdata, m_wstrb, cyc};
            obs_q.push_back(resp_cur);
            resp_cnt  = mem_lat;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Issues one request and returns one cycle after its ack with s_valid dropped.
   task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                         output int t_req, output int t_ack, output logic [31:0] rd);
      t_req   = cyc;
      s_valid = 1; s_addr = a; s_wdata = d; s_wstrb = st;
      exp_q.push_back('{a, (st == 0) ? 32'h0 : d, st, 0});
      t_ack = -1;
      rd    = 'x;
      for (int i = 0; i < 200; i++) begin
         step();
         if (s_ready) begin
            t_ack = cyc;
            rd    = s_rdata;
            break;
         end
      end
      if (t_ack < 0) begin
         n_checks++; n_errors++;
         $display("FAIL req_timeout addr=%h: no s_ready within 200 cycles", a);
      end
      step();
      s_valid = 0; s_wstrb = 0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         if (empty && !m_valid && resp_cnt == 0) begin ok = 1; break; end
         step();
      end
      if (!ok) begin
         n_checks++; n_errors++;
         $display("FAIL %s_drain_timeout: level=%0d m_valid=%b", name, level, m_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) step();
      n_checks++;
      if ({s_ready, m_valid, empty, full} !== 4'b0010) begin
         n_errors++;
         $display("FAIL reset_flags: got s_ready,m_valid,empty,full=%b want 0010",
                  {s_ready, m_valid, empty, full});
      end
      n_checks++;
      if (level !== 3'd0 || s_rdata !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_level_rdata: got level=%0d s_rdata=%h want 0/0", level, s_rdata);
      end
      n_checks++;
      if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_wstrb !== 4'h0) begin
         n_errors++;
         $display("FAIL reset_mbus: got %h/%h/%h want zeros", m_addr, m_wdata, m_wstrb);
      end
      rst = 0;
      step();
   endtask

   task automatic test_single_write();
      int t, ta;
      logic [31:0] rd;
      req_t e, o;
      mem_lat = 1;
      do_req(32'h100, 32'hDEADBEEF, 4'hF, t, ta, rd);
      n_checks++;
      if (ta !== t + 1) begin
         n_errors++;
         $display("FAIL single_ack_latency: got cycle %0d want %0d", ta, t + 1);
      end
      n_checks++;
      if (level !== 3'd1 || m_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL single_level_busy: got level=%0d m_valid=%b want 1/1", level, m_valid);
      end
      step(); step();
      n_checks++;
      if (level !== 3'd0 || empty !== 1'b1 || m_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL single_drained: got level=%0d empty=%b m_valid=%b want 0/1/0",
                  level, empty, m_valid);
      end
      wait_idle("single");
      n_checks++;
      if (obs_q.size() == 0 || obs_q[0].c !== t + 2) begin
         n_errors++;
         $display("FAIL single_mvalid_time: got %0d want %0d",
                  (obs_q.size() == 0) ? -1 : obs_q[0].c, t + 2);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_errors++;
            $display("FAIL single_payload: missing request, want addr=%h", e.a);
         end else begin
            o = obs_q.pop_front();
            if (o.a !== e.a || o.d !== e.d || o.s !== e.s) begin
               n_errors++;
               $display("FAIL single_payload: got %h/%h/%h want %h/%h/%h",
                        o.a, o.d, o.s, e.a, e.d, e.s);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int t0, t, ta[5];
      logic [31:0] rd;
      req_t e, o;
      mem_lat = 10;
      for (int i = 0; i < 4; i++) begin
         do_req(32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF, t, ta[i], rd);
         if (i == 0) t0 = t;
      end
      n_checks++;
      if (full !== 1'b1 || level !== 3'd4) begin
         n_errors++;
         $display("FAIL b2b_full: got full=%b level=%0d want 1/4", full, level);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (ta[i] !== t0 + 1 + 2 * i) begin
            n_errors++;
            $display("FAIL b2b_ack%0d: got cycle %0d want %0d", i, ta[i], t0 + 1 + 2 * i);
         end
      end
      do_req(32'h1010, 32'hA0000004, 4'hF, t, ta[4], rd);
      n_checks++;
      if (ta[4] !== t0 + 14) begin
         n_errors++;
         $display("FAIL b2b_stalled_ack: got cycle %0d want %0d", ta[4], t0 + 14);
      end
      wait_idle("b2b");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_errors++;
            $display("FAIL b2b_order: missing request, want addr=%h", e.a);
         end else begin
            o = obs_q.pop_front();
            if (o.a !== e.a || o.d !== e.d || o.s !== e.s) begin
               n_errors++;
               $display("FAIL b2b_order: got %h/%h/%h want %h/%h/%h",
                        o.a, o.d, o.s, e.a, e.d, e.s);
            end
         end
      end
   endtask

   task automatic test_read_after_write();
      int t, tw, tr, ta;
      logic [31:0] rd;
      req_t e, o;
      mem_lat = 1;
      do_req(32'h200, 32'h00000055, 4'h1, tw, ta, rd);
      do_req(32'h200, 32'h0, 4'h0, t, tr, rd);
      n_checks++;
      if (obs_q.size() < 2 || obs_q[1].c !== tw + 5 || obs_q[1].c <= obs_q[0].c + 1) begin
         n_errors++;
         $display("FAIL raw_read_order: got read m_valid cycle %0d want %0d",
                  (obs_q.size() < 2) ? -1 : obs_q[1].c, tw + 5);
      end
      n_checks++;
      if (tr !== tw + 7 || rd !== 32'h00000055) begin
         n_errors++;
         $display("FAIL raw_rdata: got cycle %0d data %h want %0d/00000055", tr, rd, tw + 7);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_errors++;
            $display("FAIL raw_payload: missing request, want addr=%h", e.a);
         end else begin
            o = obs_q.pop_front();
            if (o.a !== e.a || o.d !== e.d || o.s !== e.s) begin
               n_errors++;
               $display("FAIL raw_payload: got %h/%h/%h want %h/%h/%h",
                        o.a, o.d, o.s, e.a, e.d, e.s);
            end
         end
      end
   endtask

   task automatic test_read_empty();
      int t, ta;
      logic [31:0] rd;
      req_t e, o;
      mem_lat = 1;
      mem[32'h300] = 32'h12345678;
      do_req(32'h300, 32'h0, 4'h0, t, ta, rd);
      n_checks++;
      if (obs_q.size() == 0 || obs_q[0].c !== t + 1) begin
         n_errors++;
         $display("FAIL rd_mvalid_time: got %0d want %0d",
                  (obs_q.size() == 0) ? -1 : obs_q[0].c, t + 1);
      end
      n_checks++;
      if (ta !== t + 3 || rd !== 32'h12345678) begin
         n_errors++;
         $display("FAIL rd_rdata: got cycle %0d data %h want %0d/12345678", ta, rd, t + 3);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_errors++;
            $display("FAIL rd_payload: missing request, want addr=%h", e.a);
         end else begin
            o = obs_q.pop_front();
            if (o.a !== e.a || o.d !== e.d || o.s !== e.s) begin
               n_errors++;
               $display("FAIL rd_payload: got %h/%h/%h want %h/%h/%h",
                        o.a, o.d, o.s, e.a, e.d, e.s);
            end
         end
      end
   endtask

   task automatic test_reset_mid_wr();
      int t, ta, busy;
      logic [31:0] rd;
      mem_lat = 20;
      for (int i = 0; i < 3; i++)
         do_req(32'h400 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, t, ta, rd);
      n_checks++;
      if (level !== 3'd3 || m_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_rst_setup: got level=%0d m_valid=%b want 3/1", level, m_valid);
      end
      step(); step();
      #3 rst = 1;
      #1;
      n_checks++;
      if ({s_ready, m_valid, empty, full} !== 4'b0010 || level !== 3'd0 || s_rdata !== 32'h0 ||
          m_addr !== 32'h0 || m_wdata !== 32'h0 || m_wstrb !== 4'h0) begin
         n_errors++;
         $display("FAIL mid_rst_outputs: got flags=%b level=%0d rdata=%h m=%h/%h/%h want 0010/0/0/0/0/0",
                  {s_ready, m_valid, empty, full}, level, s_rdata, m_addr, m_wdata, m_wstrb);
      end
      step(); step();
      rst = 0;
      exp_q.delete();
      obs_q.delete();
      busy = 0;
      repeat (25) begin
         step();
         if (m_valid) busy++;
      end
      n_checks++;
      if (busy != 0 || obs_q.size() != 0 || level !== 3'd0) begin
         n_errors++;
         $display("FAIL mid_rst_quiet: got %0d m_valid cycles, %0d requests, level=%0d want 0/0/0",
                  busy, obs_q.size(), level);
      end
   endtask

   initial begin
      rst = 1;
      s_valid = 0; s_addr = 0; s_wdata = 0; s_wstrb = 0;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_read_after_write();
      test_read_empty();
      test_reset_mid_wr();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/iob_dbus_wbuf.md
# iob_dbus_wbuf

Posted-write buffer between the VexRiscv core wrapper's native data bus and the data interconnect. It accepts core writes into a DEPTH-entry FIFO and acknowledges them without waiting for memory, then drains them to the downstream bus in order. Reads are held until every buffered write has completed, so they never bypass writes. Address, data and strobe pass through unchanged.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- DEPTH_LOG2, 2, log2 of the FIFO depth (DEPTH=4)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  upstream request valid, held with payload until the cycle after s_ready
- s_addr  in  ADDR_W  upstream address
- s_wdata  in  DATA_W  upstream write data
- s_wstrb  in  DATA_W/8  upstream byte strobes; nonzero means write, zero means read
- s_rdata  out  DATA_W  read data, valid while s_ready=1
- s_ready  out  1  one-cycle registered completion pulse
- m_valid  out  1  downstream request valid, registered
- m_addr  out  ADDR_W  downstream address, registered
- m_wdata  out  DATA_W  downstream write data, registered
- m_wstrb  out  DATA_W/8  downstream strobes, registered; 0 for reads
- m_rdata  in  DATA_W  downstream read data, sampled when m_ready=1
- m_ready  in  1  downstream completion, one cycle, at least one cycle after m_valid rises
- level  out  DEPTH_LOG2+1  buffered write count
- empty  out  1  level==0
- full  out  1  level==DEPTH

## Operation
- Write acceptance happens when s_valid and s_wstrb!=0 and !full and !s_ready. On acceptance, {addr,wdata,wstrb} is pushed and s_ready pulses in the next cycle.
- A write arriving while full waits with no s_ready until a pop frees an entry. There is no same-cycle push-on-pop when full.
- The s_ready=1 cycle never accepts, because the master still holds s_valid in that cycle.
- The downstream FSM has three states: IDLE, WR and RD.
  - IDLE, level!=0: load the head entry onto the m_* registers, set m_valid=1, go to WR.
  - IDLE, level==0, s_valid read, !s_ready: load m_addr=s_addr, m_wstrb=0, m_wdata=0, m_valid=1, go to RD. This is read acceptance.
  - IDLE otherwise: stay. Buffered writes always take priority over a read.
  - WR: hold m_*. On m_ready, pop the FIFO, clear m_valid and go to IDLE.
  - RD: hold m_*. On m_ready, register s_rdata=m_rdata, pulse s_ready next cycle, clear m_valid and go to IDLE.
- level updates by level+push-pop each cycle; simultaneous push and pop leaves it unchanged.
- FIFO pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- s_rdata holds its last value after a read; it is only meaningful with s_ready.
- Reset, including mid-transaction, discards all entries and any in-flight downstream transfer and returns the FSM to IDLE.

## Timing
- Reset values: s_ready=0, s_rdata=0, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, level=0, empty=1, full=0.
- Write acknowledge latency is 1 cycle: accept in cycle T, s_ready in T+1. This is independent of downstream latency.
- Write drain with empty FIFO: push at the end of T, level=1 in T+1, m_valid in T+2.
- With 1-cycle memory (m_ready in T+3), the pop happens at the end of T+3 and the next m_valid is in T+5. Sustained drain is one write per 3 cycles.
- Read with empty FIFO and idle FSM: s_valid in T, m_valid in T+1, m_ready in T+2, s_ready with s_rdata in T+3.
- Read behind N buffered writes: the read issues in the IDLE cycle after the last pop.
- m_* remain stable from m_valid rise through the m_ready cycle. m_valid drops in the cycle after m_ready.

## Test plan
- Reset mid-WR with level=3 and m_valid=1, rst asserted in an arbitrary cycle:
  - all outputs reach their reset values immediately;
  - after release, no downstream request is issued.
- Single write to 0x100 with wdata 0xDEADBEEF and wstrb 0xF:
  - s_ready at T+1;
  - m_valid at T+2 with identical payload;
  - level goes 1 then 0 after m_ready.
- Four back-to-back writes with m_ready delayed 10 cycles:
  - all four ack at 2-cycle spacing, full=1 after the fourth;
  - a fifth write stalls until the first pop, then acks;
  - downstream order is unchanged.
- Write 0x55 to 0x200 (wstrb 0x1), then an immediate read of 0x200 with 1-cycle memory:
  - the read m_valid appears only after the write's m_ready;
  - s_rdata equals the memory model value 0x55 in the s_ready cycle.
- Read of 0x300 on empty buffer, memory returns 0x12345678:
  - m_valid at T+1 with m_wstrb=0;
  - s_ready with s_rdata=0x12345678 at T+3.
